// File: rtl/sprite_blitter.sv
// sprite_blitter: walks a 1-bpp sprite ROM row by row and emits one
// pixel-write request per set bit over a valid/ready handshake.
// Optional feature: define SPRITE_BLITTER_CLIP_EN to drop off-screen pixels.
module sprite_blitter #(
  parameter int unsigned ROWS     = 60,
  parameter int unsigned COLS     = 51,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [X_W-1:0]  x0,
  input  logic [Y_W-1:0]  y0,
  output logic            busy,
  output logic            done,
  output logic [5:0]      rom_addr,
  input  logic [COLS-1:0] rom_data,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [X_W-1:0]  wr_x,
  output logic [Y_W-1:0]  wr_y
);

  localparam int unsigned AW = 6;
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SCAN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [X_W-1:0]  x0_q, x0_d;
  logic [Y_W-1:0]  y0_q, y0_d;
  logic [AW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] line_q, line_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_valid_q, wr_valid_d;
  logic [X_W-1:0]  wr_x_q, wr_x_d;
  logic [Y_W-1:0]  wr_y_q, wr_y_d;

  // Pixel that becomes current on the next cycle.
  logic            pix_load;
  logic            pix_bit;
  logic [CW-1:0]   pix_col;
  logic [AW-1:0]   pix_row;
`ifdef SPRITE_BLITTER_CLIP_EN
  logic [X_W:0]    x_sum;
  logic [Y_W:0]    y_sum;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      line_q     <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      row_q      <= row_d;
      col_q      <= col_d;
      line_q     <= line_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
    end
  end

  // Next-state logic; outputs are precomputed one cycle ahead so they register cleanly.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    row_d      = row_q;
    col_d      = col_q;
    line_d     = line_q;
    rom_addr_d = rom_addr_q;
    wr_valid_d = wr_valid_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    pix_load   = 1'b0;
    pix_bit    = 1'b0;
    pix_col    = '0;
    pix_row    = '0;
`ifdef SPRITE_BLITTER_CLIP_EN
    x_sum      = '0;
    y_sum      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d       = x0;
          y0_d       = y0;
          row_d      = '0;
          col_d      = '0;
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        line_d   = rom_data;
        col_d    = '0;
        state_d  = S_SCAN;
        pix_load = 1'b1;
        pix_bit  = rom_data[COLS-1];
        pix_col  = '0;
        pix_row  = row_q;
      end
      S_SCAN: begin
        // A column is consumed when it has no request or the request is accepted.
        if (!wr_valid_q || wr_ready) begin
          if (col_q == CW'(COLS - 1)) begin
            wr_valid_d = 1'b0;
            if (row_q == AW'(ROWS - 1)) begin
              state_d = S_DONE;
            end else begin
              row_d      = AW'(row_q + AW'(1));
              rom_addr_d = AW'(row_q + AW'(1));
              state_d    = S_FETCH;
            end
          end else begin
            col_d    = CW'(col_q + CW'(1));
            line_d   = line_q << 1;
            pix_load = 1'b1;
            pix_bit  = line_q[COLS-2];
            pix_col  = CW'(col_q + CW'(1));
            pix_row  = row_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pix_load) begin
`ifdef SPRITE_BLITTER_CLIP_EN
      x_sum      = {1'b0, x0_q} + (X_W+1)'(pix_col);
      y_sum      = {1'b0, y0_q} + (Y_W+1)'(pix_row);
      wr_x_d     = x_sum[X_W-1:0];
      wr_y_d     = y_sum[Y_W-1:0];
      wr_valid_d = pix_bit && (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
`else
      wr_x_d     = X_W'(x0_q + X_W'(pix_col));
      wr_y_d     = Y_W'(y0_q + Y_W'(pix_row));
      wr_valid_d = pix_bit;
`endif
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign wr_valid = wr_valid_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;

endmodule
